button_press_classifier: RTL
============================

// Module: button_press_classifier
// PURPOSE
//  Consumes the debounced, active-high button state and one-cycle down/up pulses.
//  Classifies each press as short or long, then emits auto-repeat pulses while held.
//  One instance per debounced button; outputs drive the time-set/mode logic.
//  Timing runs off an internal ms-tick prescaler that restarts on every press.
// PARAMETERS
//  TICK_DIV   100000  clk cycles per ms tick (1 ms at 100 MHz); >= 2
//  LONG_MS    1000    hold time in ticks that turns a press into a long press; >= 1
//  REPEAT_MS  200     interval in ticks between repeat pulses once long; >= 1
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  btn_state    in   1  debounced level, 1 = pressed
//  btn_down     in   1  1-cycle pulse on debounced press
//  btn_up       in   1  1-cycle pulse on debounced release
//  short_press  out  1  1-cycle pulse: released before LONG_MS
//  long_press   out  1  1-cycle pulse: LONG_MS reached while held
//  repeat_pulse out  1  1-cycle pulse every REPEAT_MS after long_press while held
//  held         out  1  level, 1 while in HELD state
// BEHAVIOUR
//  - All outputs are registered. On rst: every output is 0, state = IDLE, counters = 0.
//  - Prescaler: pre_cnt counts 0..TICK_DIV-1 and wraps. tick = (pre_cnt == TICK_DIV-1).
//    Width is clog2(TICK_DIV).
//  - ms_cnt: width clog2(max(LONG_MS, REPEAT_MS) + 1). It increments on tick and never wraps.
//  - FSM IDLE / PRESSED / HELD:
//    IDLE:    btn_down -> PRESSED; pre_cnt = 0, ms_cnt = 0. btn_up is ignored.
//    PRESSED: on tick, ms_cnt++.
//             btn_up -> IDLE, and short_press = 1 in the next cycle.
//             Else, if tick and ms_cnt == LONG_MS-1 -> HELD; ms_cnt = 0, pre_cnt = 0,
//             and long_press = 1 in the next cycle.
//    HELD:    on tick, ms_cnt++. If tick and ms_cnt == REPEAT_MS-1: repeat_pulse = 1
//             in the next cycle, and ms_cnt = 0.
//             btn_up -> IDLE with no pulse. held = 1 while in this state.
//  - Timing, with btn_down at cycle T:
//    long_press is high in cycle T + LONG_MS*TICK_DIV + 1.
//    repeat_pulse is high LONG_MS*TICK_DIV + k*REPEAT_MS*TICK_DIV + 1 cycles after T, for k = 1, 2, ...
//  - Simultaneous events:
//    btn_up in the same cycle as the LONG_MS tick: the release wins. short_press is issued,
//    long_press is not.
//    btn_up in the same cycle as a repeat tick: no repeat_pulse; go to IDLE.
//  - btn_down while in PRESSED or HELD is ignored (no timer restart).
//  - Lost release: in PRESSED or HELD, btn_state == 0 with btn_up == 0 -> IDLE silently.
//    No pulse is issued.
//  - Reset mid-press: after rst the block is in IDLE even if btn_state == 1. No event is
//    issued until a new btn_down.
//  - At most one of short_press, long_press, repeat_pulse is high in any cycle.
// TESTING (TICK_DIV=4, LONG_MS=5, REPEAT_MS=2; btn_down at cycle T; btn_state follows the pulses)
//  1. Short press: btn_up at T+10 -> short_press=1 only at T+11; no other pulse; held stays 0.
//  2. Long hold: release at T+50 -> long_press at T+21; held=1 from T+21;
//     repeat_pulse at T+29, T+37, T+45; no short; held=0 at T+51.
//  3. Boundary: btn_up at T+20 -> short_press at T+21, no long_press.
//     Second run, btn_up at T+21 -> long_press at T+21, no short_press.
//  4. Lost release: drop btn_state at T+12 with no btn_up -> IDLE; no pulses.
//     Next btn_down restarts timing.
//  5. rst asserted at T+15 while pressed -> all outputs 0. No pulse on the later btn_up.
//     A fresh press after rst classifies normally.
//  6. Spurious btn_down at T+8 while PRESSED -> ignored; long_press still at T+21.

Source files
------------

// File: rtl/button_press_classifier.sv
// Classifies a debounced button press as short or long, then auto-repeats while held.
// Timing comes from a ms-tick prescaler that restarts on each accepted press.
module button_press_classifier #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_state,
    input  logic btn_down,
    input  logic btn_up,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned MS_W   = $clog2(MS_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]  LONG_LAST = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]  REP_LAST  = MS_W'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic             tick;
    logic [MS_W-1:0]  ms_inc;

    assign tick   = (pre_cnt == PRE_LAST);
    // ms_cnt saturates rather than wrapping
    assign ms_inc = (ms_cnt == '1) ? ms_cnt : ms_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pre_cnt      <= '0;
            ms_cnt       <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (btn_down) begin
                        state   <= PRESSED;
                        pre_cnt <= '0;
                        ms_cnt  <= '0;
                    end
                end

                PRESSED: begin
                    // release takes priority over a coincident LONG_MS tick
                    if (btn_up) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                    end else if (!btn_state) begin
                        state <= IDLE;
                    end else if (tick && ms_cnt == LONG_LAST) begin
                        state      <= HELD;
                        held       <= 1'b1;
                        long_press <= 1'b1;
                        ms_cnt     <= '0;
                        pre_cnt    <= '0;
                    end else if (tick) begin
                        ms_cnt <= ms_inc;
                    end
                end

                HELD: begin
                    if (btn_up || !btn_state) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else if (tick) begin
                        if (ms_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            ms_cnt       <= '0;
                        end else begin
                            ms_cnt <= ms_inc;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule
